// File: rtl/decode_address_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined address decoder.
package decode_address_pkg;

  localparam int MODE_ONEHOT = 0;
  localparam int MODE_THERM  = 1;

  // Number of register stages needed to resolve aw tree levels, l levels at a time.
  function automatic int num_stages(input int aw, input int l);
    return (aw + l - 1) / l;
  endfunction

  // Tree levels resolved once k stages have been passed (clamped to the address width).
  function automatic int levels_done(input int k, input int l, input int aw);
    return ((k * l) < aw) ? (k * l) : aw;
  endfunction

  // Width of the partial decode vector held in the register of stage k.
  function automatic int stage_width(input int k, input int l, input int aw);
    return 1 << levels_done(k + 1, l, aw);
  endfunction

endpackage

// File: rtl/decode_address_stage.sv
// One pipeline stage: expands the partial one-hot vector by LEVELS tree levels
// using the next address MSBs, then registers it behind a valid/ready handshake.
module decode_address_stage
  import decode_address_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int IN_LEVELS  = 0,
  parameter int LEVELS     = 1,
  parameter bit THERM      = 1'b0
) (
  input  logic                                  Clock,
  input  logic                                  Reset,
  input  logic                                  Flush,
  input  logic                                  i_valid,
  output logic                                  o_ready,
  input  logic [(1 << IN_LEVELS)-1:0]           i_vec,
  input  logic [ADDR_WIDTH-1:0]                 i_addr,
  output logic                                  o_valid,
  input  logic                                  i_ready,
  output logic [(1 << (IN_LEVELS + LEVELS))-1:0] o_vec,
  output logic [ADDR_WIDTH-1:0]                 o_addr
);

  localparam int IN_W  = 1 << IN_LEVELS;
  localparam int OUT_W = 1 << (IN_LEVELS + LEVELS);

  logic             r_valid;
  logic [OUT_W-1:0] r_vec;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [OUT_W-1:0] w_exp;
  logic [OUT_W-1:0] w_fill;
  logic             w_load;

  // Tree expansion: parent p feeds 2p (address bit 0) and 2p+1 (address bit 1), MSB first.
  always_comb begin
    logic [OUT_W-1:0] v;
    logic [OUT_W-1:0] n;
    v = '0;
    n = '0;
    v[IN_W-1:0] = i_vec;
    for (int j = 0; j < LEVELS; j++) begin
      n = '0;
      for (int p = 0; p < OUT_W / 2; p++) begin
        n[2*p]   = v[p] & ~i_addr[ADDR_WIDTH-1-j];
        n[2*p+1] = v[p] &  i_addr[ADDR_WIDTH-1-j];
      end
      v = n;
    end
    w_exp = v;
  end

  // Optional thermometer fill: bit i is set when any one-hot bit at or above i is set.
  always_comb begin
    logic acc;
    acc    = 1'b0;
    w_fill = w_exp;
    if (THERM) begin
      for (int i = OUT_W - 1; i >= 0; i--) begin
        acc       = acc | w_exp[i];
        w_fill[i] = acc;
      end
    end
  end

  // A stage loads when empty or when its current entry moves on this cycle; flush blocks loading.
  assign w_load  = ~Flush & (~r_valid | i_ready);
  assign o_ready = w_load & ~Reset;

  // Stage register: data only captured on a real transfer, so a stalled entry holds untouched.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_valid <= 1'b0;
      r_vec   <= '0;
      r_addr  <= '0;
    end else if (Flush) begin
      r_valid <= 1'b0;
      r_vec   <= '0;
    end else if (w_load) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_vec  <= w_fill;
        r_addr <= i_addr << LEVELS;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_vec   = r_vec;
  assign o_addr  = r_addr;

endmodule

// File: rtl/decode_address_pipe.sv
// Pipelined binary-to-one-hot (or thermometer) address decoder with valid/ready
// at both ends. The root of the decode tree is Enable; each stage resolves
// LEVELS_PER_STAGE address MSBs, the last stage taking whatever remains.
module decode_address_pipe
  import decode_address_pkg::*;
#(
  parameter int ADDR_WIDTH       = 4,
  parameter int LEVELS_PER_STAGE = 1,
  parameter int MODE             = MODE_ONEHOT
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Flush,
  input  logic                         InValid,
  output logic                         InReady,
  input  logic                         Enable,
  input  logic [ADDR_WIDTH-1:0]        ToDecode,
  output logic                         OutValid,
  input  logic                         OutReady,
  output logic [(1 << ADDR_WIDTH)-1:0] Decoded
);

  localparam int NSTAGES = num_stages(ADDR_WIDTH, LEVELS_PER_STAGE);

  // Handshake chain: index k is the boundary feeding stage k; index NSTAGES is the output.
  logic w_valid [0:NSTAGES];
  logic w_ready [0:NSTAGES];
  logic [ADDR_WIDTH-1:0] w_addr_unused;

  assign w_valid[0]       = InValid;
  assign w_ready[NSTAGES] = OutReady;
  assign InReady          = w_ready[0];
  assign OutValid         = w_valid[NSTAGES];

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    localparam int IN_LV  = levels_done(k, LEVELS_PER_STAGE, ADDR_WIDTH);
    localparam int OUT_LV = levels_done(k + 1, LEVELS_PER_STAGE, ADDR_WIDTH);

    logic [(1 << IN_LV)-1:0]  w_vec_in;
    logic [(1 << OUT_LV)-1:0] w_vec_out;
    logic [ADDR_WIDTH-1:0]    w_addr_in;
    logic [ADDR_WIDTH-1:0]    w_addr_out;

    if (k == 0) begin : g_root
      assign w_vec_in  = Enable;
      assign w_addr_in = ToDecode;
    end else begin : g_link
      assign w_vec_in  = g_stage[k-1].w_vec_out;
      assign w_addr_in = g_stage[k-1].w_addr_out;
    end

    decode_address_stage #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .IN_LEVELS  (IN_LV),
      .LEVELS     (OUT_LV - IN_LV),
      .THERM      ((MODE == MODE_THERM) && (k == NSTAGES - 1))
    ) u_stage (
      .Clock   (Clock),
      .Reset   (Reset),
      .Flush   (Flush),
      .i_valid (w_valid[k]),
      .o_ready (w_ready[k]),
      .i_vec   (w_vec_in),
      .i_addr  (w_addr_in),
      .o_valid (w_valid[k+1]),
      .i_ready (w_ready[k+1]),
      .o_vec   (w_vec_out),
      .o_addr  (w_addr_out)
    );

    if (k == NSTAGES - 1) begin : g_tail
      assign Decoded       = w_vec_out;
      assign w_addr_unused = w_addr_out;
    end
  end

endmodule

// File: tb/tb_decode_address_pipe.sv
// Bench for decode_address_pipe: one-hot (4,2), thermometer (4,2) and an uneven
// split (5,2) share stimulus; a queue-based reference tracks every transaction.
module tb_decode_address_pipe;

  logic        Clock = 1'b0;
  logic        Reset, Flush, InValid, Enable, OutReady;
  logic [4:0]  td5;
  logic        ir0, ov0, ir1, ov1, ir2, ov2;
  logic [15:0] dec0, dec1;
  logic [31:0] dec2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clock = ~Clock;

  decode_address_pipe #(.ADDR_WIDTH(4), .LEVELS_PER_STAGE(2), .MODE(0)) dut0 (
    .Clock(Clock), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InReady(ir0),
    .Enable(Enable), .ToDecode(td5[3:0]), .OutValid(ov0), .OutReady(OutReady), .Decoded(dec0));

  decode_address_pipe #(.ADDR_WIDTH(4), .LEVELS_PER_STAGE(2), .MODE(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InReady(ir1),
    .Enable(Enable), .ToDecode(td5[3:0]), .OutValid(ov1), .OutReady(OutReady), .Decoded(dec1));

  decode_address_pipe #(.ADDR_WIDTH(5), .LEVELS_PER_STAGE(2), .MODE(0)) dut2 (
    .Clock(Clock), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InReady(ir2),
    .Enable(Enable), .ToDecode(td5), .OutValid(ov2), .OutReady(OutReady), .Decoded(dec2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          nst [3] = '{2, 2, 3};
  logic [31:0] fifo [3][8];
  int          rd [3] = '{0, 0, 0};
  int          wr [3] = '{0, 0, 0};
  logic        prev_hold [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] prev_dec [3];

  function automatic logic [31:0] exp_val(input int id, input logic en, input logic [4:0] a);
    if (!en) return 32'h0;
    case (id)
      0:       return 32'd1 << a[3:0];
      1:       return (32'd2 << a[3:0]) - 32'd1;
      default: return 32'd1 << a;
    endcase
  endfunction

  task automatic mon(input int id, input logic ov, input logic ir, input logic [31:0] dec);
    int   occ;
    logic exp_ir;
    occ = wr[id] - rd[id];
    if (Reset) begin
      chk($sformatf("rst_ov%0d", id), {31'h0, ov}, 32'h0);
      chk($sformatf("rst_ir%0d", id), {31'h0, ir}, 32'h0);
      chk($sformatf("rst_dec%0d", id), dec, 32'h0);
      rd[id] = 0; wr[id] = 0; prev_hold[id] = 1'b0;
    end else begin
      // Any empty slot lets a request in; a full pipe accepts only alongside a consume.
      exp_ir = !Flush && ((occ < nst[id]) || OutReady);
      chk($sformatf("ready%0d", id), {31'h0, ir}, {31'h0, exp_ir});
      if (prev_hold[id]) begin
        chk($sformatf("hold_ov%0d", id), {31'h0, ov}, 32'h1);
        chk($sformatf("hold_dec%0d", id), dec, prev_dec[id]);
      end
      if (ov) begin
        if (occ == 0) chk($sformatf("spurious_ov%0d", id), {31'h0, ov}, 32'h0);
        else          chk($sformatf("data%0d", id), dec, fifo[id][rd[id] % 8]);
      end
      prev_hold[id] = ov && !OutReady && !Flush;
      prev_dec[id]  = dec;
      if (Flush) begin
        rd[id] = 0; wr[id] = 0;
      end else begin
        if (ov && OutReady && occ > 0) rd[id]++;
        if (InValid && ir) begin
          fifo[id][wr[id] % 8] = exp_val(id, Enable, td5);
          wr[id]++;
        end
      end
    end
  endtask

  always @(negedge Clock) begin
    #2;
    mon(0, ov0, ir0, {16'h0, dec0});
    mon(1, ov1, ir1, {16'h0, dec1});
    mon(2, ov2, ir2, dec2);
  end

  // ---------------- directed + random stimulus ----------------
  typedef struct {
    logic        en;
    logic [3:0]  a;
    logic [15:0] oh;
    logic [15:0] th;
  } vec_t;

  vec_t tbl [7];

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic idle(input int n);
    InValid = 1'b0; OutReady = 1'b1; Flush = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    tbl[0] = '{1'b1, 4'h9, 16'h0200, 16'h03FF};
    tbl[1] = '{1'b1, 4'h4, 16'h0010, 16'h001F};
    tbl[2] = '{1'b1, 4'hF, 16'h8000, 16'hFFFF};
    tbl[3] = '{1'b0, 4'hF, 16'h0000, 16'h0000};
    tbl[4] = '{1'b1, 4'h0, 16'h0001, 16'h0001};
    tbl[5] = '{1'b1, 4'h3, 16'h0008, 16'h000F};
    tbl[6] = '{1'b1, 4'h7, 16'h0080, 16'h00FF};

    Reset = 1'b1; Flush = 1'b0; InValid = 1'b0; Enable = 1'b1; OutReady = 1'b1; td5 = '0;
    #7;
    chk("reset_inready", {31'h0, ir0}, 32'h0);
    chk("reset_outvalid", {31'h0, ov0}, 32'h0);
    chk("reset_decoded", {16'h0, dec0}, 32'h0);
    tick(); tick();

    // Release and push 0x9 in the very first cycle.
    Reset = 1'b0; InValid = 1'b1; Enable = 1'b1; td5 = 5'h09;
    #1;
    chk("t1_inready", {31'h0, ir0}, 32'h1);
    chk("t1_c0_ov", {31'h0, ov0}, 32'h0);
    tick(); InValid = 1'b0;
    #1;
    chk("t1_c1_ov", {31'h0, ov0}, 32'h0);
    chk("t1_c1_dec", {16'h0, dec0}, 32'h0);
    tick(); #1;
    chk("t1_c2_ov", {31'h0, ov0}, 32'h1);
    chk("t1_c2_dec", {16'h0, dec0}, 32'h0200);
    idle(5);

    // Table: single transactions, one-hot and thermometer side by side.
    for (int i = 0; i < 7; i++) begin
      InValid = 1'b1; Enable = tbl[i].en; td5 = {1'b0, tbl[i].a}; OutReady = 1'b1;
      tick(); InValid = 1'b0;
      tick(); #1;
      chk($sformatf("tbl%0d_ov", i), {31'h0, ov0}, 32'h1);
      chk($sformatf("tbl%0d_onehot", i), {16'h0, dec0}, {16'h0, tbl[i].oh});
      chk($sformatf("tbl%0d_ov_th", i), {31'h0, ov1}, 32'h1);
      chk($sformatf("tbl%0d_therm", i), {16'h0, dec1}, {16'h0, tbl[i].th});
      idle(5);
    end

    // Back-to-back stream 0..15 at full throughput.
    Enable = 1'b1; OutReady = 1'b1;
    for (int c = 0; c < 18; c++) begin
      InValid = (c < 16);
      td5 = 5'(c);
      #1;
      if (c < 16) chk($sformatf("stream_ready%0d", c), {31'h0, ir0}, 32'h1);
      chk($sformatf("stream_ov%0d", c), {31'h0, ov0}, {31'h0, (c >= 2)});
      if (c >= 2) chk($sformatf("stream_dec%0d", c), {16'h0, dec0}, 32'd1 << (c - 2));
      tick();
    end
    idle(5);

    // Backpressure: fill with 0x3, 0x5 then hold.
    OutReady = 1'b0; InValid = 1'b1; Enable = 1'b1; td5 = 5'h03;
    #1 chk("bp_ready0", {31'h0, ir0}, 32'h1);
    tick(); td5 = 5'h05;
    #1 chk("bp_ready1", {31'h0, ir0}, 32'h1);
    tick(); td5 = 5'h07;
    for (int h = 0; h < 3; h++) begin
      #1;
      chk($sformatf("bp_full_ready%0d", h), {31'h0, ir0}, 32'h0);
      chk($sformatf("bp_hold_dec%0d", h), {16'h0, dec0}, 32'h0008);
      chk($sformatf("bp_hold_ov%0d", h), {31'h0, ov0}, 32'h1);
      tick();
    end
    InValid = 1'b0; OutReady = 1'b1;
    #1 chk("bp_rel_dec0", {16'h0, dec0}, 32'h0008);
    tick(); #1;
    chk("bp_rel_ov1", {31'h0, ov0}, 32'h1);
    chk("bp_rel_dec1", {16'h0, dec0}, 32'h0020);
    tick(); #1;
    chk("bp_rel_ov2", {31'h0, ov0}, 32'h0);
    idle(5);

    // Flush with two entries in flight; the same-cycle request is refused.
    OutReady = 1'b0; InValid = 1'b1; td5 = 5'h01;
    tick(); td5 = 5'h02;
    tick(); Flush = 1'b1; td5 = 5'h06;
    #1 chk("flush_inready", {31'h0, ir0}, 32'h0);
    tick(); Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    #1;
    chk("flush_ov", {31'h0, ov0}, 32'h0);
    chk("flush_dec", {16'h0, dec0}, 32'h0);
    chk("flush_dec_th", {16'h0, dec1}, 32'h0);
    InValid = 1'b1; td5 = 5'h0C;
    tick(); InValid = 1'b0;
    #1 chk("flush_next_ov0", {31'h0, ov0}, 32'h0);
    tick(); #1;
    chk("flush_next_ov1", {31'h0, ov0}, 32'h1);
    chk("flush_next_dec", {16'h0, dec0}, 32'h1000);
    tick(); #1;
    chk("flush_no_ghost", {31'h0, ov0}, 32'h0);
    idle(5);

    // Asynchronous reset mid-stream.
    OutReady = 1'b0; InValid = 1'b1; td5 = 5'h0B;
    tick(); td5 = 5'h0E;
    tick(); InValid = 1'b0; Reset = 1'b1;
    #1;
    chk("rst_mid_ov", {31'h0, ov0}, 32'h0);
    chk("rst_mid_dec", {16'h0, dec0}, 32'h0);
    chk("rst_mid_ready", {31'h0, ir0}, 32'h0);
    tick(); Reset = 1'b0; OutReady = 1'b1; InValid = 1'b1; td5 = 5'h0A;
    #1 chk("rst_rel_ready", {31'h0, ir0}, 32'h1);
    tick(); InValid = 1'b0;
    tick(); #1;
    chk("rst_next_ov", {31'h0, ov0}, 32'h1);
    chk("rst_next_dec", {16'h0, dec0}, 32'h0400);
    idle(5);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 1500; c++) begin
      InValid  = ($urandom_range(0, 9) < 7);
      Enable   = ($urandom_range(0, 9) < 9);
      OutReady = ($urandom_range(0, 9) < 6);
      Flush    = ($urandom_range(0, 49) == 0);
      td5      = 5'($urandom);
      tick();
    end
    idle(10);
    #3;
    for (int id = 0; id < 3; id++)
      chk($sformatf("drain%0d", id), 32'(wr[id] - rd[id]), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_address_pipe.md
Name: decode_address_pipe

Overview:
Pipelined, parametrised binary-to-one-hot address decoder, the clocked successor to the combinational 1-bit decode tree. It expands ToDecode MSB-first through an ADDR_WIDTH-level binary tree, with a register boundary every LEVELS_PER_STAGE levels and valid/ready flow control at both ends. It adds an optional thermometer output mode and a synchronous flush. It sits between address-issuing masters and select/enable fan-out logic (bank selects, register-file write enables).

Parameters:
ADDR_WIDTH, 4, number of address bits; output width is 2**ADDR_WIDTH; legal range 1..8.
LEVELS_PER_STAGE, 1, tree levels resolved per pipeline stage; legal range 1..ADDR_WIDTH.
MODE, 0, 0 = one-hot output; 1 = thermometer output (Decoded[i]=1 for all i <= address).

Ports:
Clock  input  1  rising-edge clock.
Reset  input  1  asynchronous, active-high reset.
Flush  input  1  synchronous; clears all in-flight entries.
InValid  input  1  request present.
InReady  output  1  request accepted when InValid && InReady at a rising edge.
Enable  input  1  request enable; 0 produces an all-zero Decoded for that transaction.
ToDecode  input  ADDR_WIDTH  address to decode.
OutValid  output  1  Decoded holds a completed transaction.
OutReady  input  1  consumer accepts when OutValid && OutReady.
Decoded  output  2**ADDR_WIDTH  registered decode result.

Behaviour:
- Stage count: NSTAGES = ceil(ADDR_WIDTH / LEVELS_PER_STAGE). Latency from accept to OutValid is NSTAGES cycles when there is no backpressure.
- Stage k state: valid bit; partial vector of 2**(min((k+1)*L, ADDR_WIDTH)) bits; remaining unresolved address bits (LSBs).
- Stage k consumes the next L address MSBs. Each parent bit p feeds children 2p and 2p+1, selected by the address bit (0 → left child 2p, 1 → right child 2p+1). The root is Enable.
- Numbering matches the 1-bit tree: Decoded[i] = Enable && (ToDecode == i).
- Flow control, per stage: a stage loads when it is empty or its own contents advance in the same cycle. Stage k advances when valid[k] && (k is last ? OutReady : stage k+1 loads).
- InReady = stage 0 loads. It is combinational from OutReady through the chain and has no bubbles: full throughput of 1 transaction/cycle under continuous OutReady.
- When a stage is stalled, its contents hold and are not recomputed.
- MODE=1: the thermometer conversion is applied in the last stage register. Decoded[i] = Enable && (i <= ToDecode).
- Enable=0 transactions still occupy a slot and emerge with OutValid=1 and Decoded=0.
- Reset (asynchronous assert, synchronous release): all valid bits 0, OutValid=0, Decoded=0, all partial vectors 0. InReady=0 while Reset=1 and 1 in the first cycle after release.
- Reset mid-operation: in-flight transactions are discarded, and no partial output is produced.
- Flush=1: at the clock edge all valid bits clear, Decoded clears to 0, and an input presented in the same cycle is NOT accepted (InReady forced 0). Flush has priority over OutReady; a transaction flushed while OutValid=1 counts as not consumed.
- Pipeline full with OutReady=0: InReady=0, all outputs stable. Holding OutValid=1 with Decoded stable until OutReady is mandatory.
- Simultaneous output consume and input accept when full: both occur in the same cycle and the occupancy is unchanged.
- ADDR_WIDTH not a multiple of L: the last stage resolves the remaining ADDR_WIDTH mod L levels.

Decomposition:
- Package decode_address_pkg holds:
  - MODE_ONEHOT=0 and MODE_THERM=1 constants;
  - function num_stages(aw, l);
  - function stage_width(k, l, aw) returning the partial vector width after stage k.
- Sub-module decode_address_stage (parameters IN_LEVELS, LEVELS, ADDR_WIDTH):
  - combinational L-level expansion of the partial vector;
  - followed by the stage register with valid/ready.
- The top instantiates NSTAGES of these in a generate loop, plus the thermometer post-process.

Test Plan:
(All with ADDR_WIDTH=4, L=2, MODE=0, so NSTAGES=2 unless noted.)
1. Reset release, OutReady=1; push ToDecode=0x9, Enable=1 at cycle 0 → OutValid=1 at cycle 2 with Decoded=0x0200; Decoded=0 before that.
2. Stream ToDecode 0..15 back-to-back, OutReady=1 → 16 consecutive OutValid cycles, Decoded = 1<<n in order, InReady never drops.
3. Fill the pipe with 0x3 and 0x5, OutReady=0 → InReady=0 after 2 accepts, Decoded holds 0x0008; raise OutReady → 0x0008 then 0x0020 on successive cycles.
4. Enable=0, ToDecode=0xF → OutValid=1, Decoded=0x0000; the transaction is consumed normally.
5. MODE=1, ToDecode=0x4 → Decoded=0x001F; ToDecode=0xF → 0xFFFF.
6. Two entries in flight, assert Flush (and separately Reset) mid-stream → OutValid=0, Decoded=0 next cycle (immediately for Reset); the input offered in the Flush cycle is not accepted; the next push decodes correctly.
